reg_intf_dw_downsizer: RTL and testbench
========================================

// Module: reg_intf_dw_downsizer
// PURPOSE
// - Splits one wide register-interface transaction into ratio = WIDE_DW/NARROW_DW narrow
//   beats, issued lowest lane first. Reassembles read data; ORs error across beats.
// - Sits between a wide master (e.g. 64-bit CLINT/PLIC bridge) and a narrow peripheral slave.
// - Same single-phase valid/ready protocol on both sides; no outstanding transactions.
// PARAMETERS
// - AW          32  address width, both sides
// - WIDE_DW     64  master-side data width; power of 2, >= NARROW_DW
// - NARROW_DW   32  slave-side data width; power of 2, >= 8
// - SKIP_EMPTY  1   1: write beats whose strobe slice is all-zero are not issued
// PORTS
// - clk_i           in   1             clock
// - rst_ni          in   1             asynchronous active-low reset
// - wide_addr_i     in   AW            master address
// - wide_write_i    in   1             1 = write
// - wide_wdata_i    in   WIDE_DW       write data
// - wide_wstrb_i    in   WIDE_DW/8     byte strobes
// - wide_valid_i    in   1             request valid
// - wide_rdata_o    out  WIDE_DW       assembled read data
// - wide_error_o    out  1             OR of beat errors
// - wide_ready_o    out  1             completion, one-cycle pulse
// - narrow_addr_o   out  AW            beat address
// - narrow_write_o  out  1             1 = write
// - narrow_wdata_o  out  NARROW_DW     beat write data
// - narrow_wstrb_o  out  NARROW_DW/8   beat strobes
// - narrow_valid_o  out  1             beat valid
// - narrow_rdata_i  in   NARROW_DW     beat read data
// - narrow_error_i  in   1             beat error
// - narrow_ready_i  in   1             beat completion
// BEHAVIOUR
// - Reset: all outputs 0; FSM IDLE; beat counter 0; rdata/error accumulators 0.
// - FSM IDLE -> ISSUE -> RESP -> IDLE.
//   - IDLE: on wide_valid_i, latch request; lane = first needed lane; go ISSUE.
//     If it is a write and no beat is needed (SKIP_EMPTY, wstrb == 0), go RESP directly.
//   - ISSUE: narrow_valid_o = 1, outputs registered; all narrow outputs stable until
//     narrow_ready_i. On narrow_valid_o & narrow_ready_i: store narrow_rdata_i in lane slot,
//     error_acc |= narrow_error_i, advance to next needed lane. After the last needed lane,
//     drop narrow_valid_o next cycle and go RESP.
//   - RESP: wide_ready_o = 1 for exactly one cycle, with rdata/error stable; then IDLE.
// - Beats:
//   - narrow_addr_o = {wide_addr[AW-1:log2(WIDE_DW/8)], lane, log2(NARROW_DW/8)'b0}
//     (wide address aligned; low bits dropped).
//   - narrow_wdata_o / narrow_wstrb_o = lane slice of the latched wdata/wstrb.
//   - Reads always issue all ratio beats. Unissued read lanes return 0.
// - Latency: valid at cycle 0 -> first narrow_valid_o at cycle 1; zero-wait slave gives
//   wide_ready_o at cycle 1 + beats + 1. An all-skipped write gives wide_ready_o at cycle 2.
// - Error does not abort: remaining beats are still issued.
// - Ratio 1: single beat, same FSM, same latency.
// - wide_valid_i deasserted mid-transaction: protocol violation. The transaction still
//   completes; an SVA assertion flags it. Latched request fields ignore input changes.
// - Reset mid-transaction: immediate return to reset state. narrow_valid_o drops
//   asynchronously; no completion is signalled.
// - Elaboration error if WIDE_DW % NARROW_DW != 0 or either width is not a power of 2.
// STRUCTURE
// - Package reg_intf_dw_pkg:
//   - state enum {IDLE, ISSUE, RESP};
//   - function next_lane(strb, cur, write, skip) returning next needed lane plus a done flag.
// - Existing a32_d32/a32_d64 structs map directly onto the port groups.
// - No sub-module: single FSM + lane counter + accumulator register.
// TESTING
// - 64->32 read, addr 0x1004, slave returns 0xAAAA0000 then 0x5555FFFF -> beats at 0x1000
//   and 0x1004; wide_rdata 0x5555FFFF_AAAA0000, error 0.
// - 64->32 write, wstrb 0xF0, data 0x11223344_55667788, SKIP_EMPTY=1 -> one beat at
//   0x1004, data 0x11223344, strb 0xF.
// - Write, wstrb 0x00 -> no narrow_valid_o; wide_ready_o pulses at cycle 2.
// - 128->32 read, beat 1 error=1, slave with 2 wait states -> 4 beats issued; error 1;
//   wide_ready_o at cycle 1 + 4*3 + 1 = 14.
// - rst_ni low during beat 2 of 4 -> narrow_valid_o 0 immediately; no wide_ready_o.
//   Next request runs normally from lane 0.
// - Random back-to-back traffic vs. a reference memory model, ratios 1, 2 and 4 -> data
//   matches; narrow outputs stable while valid & !ready.

Source files
------------

// File: rtl/reg_intf_dw_pkg.sv
// Shared types and lane-selection helper for the register-interface width downsizer.
package reg_intf_dw_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  localparam int MAX_LANES  = 64;
  localparam int LANE_SEL_W = 6;

  typedef struct packed {
    logic                  done;
    logic [LANE_SEL_W-1:0] lane;
  } lane_sel_t;

  // Lowest lane >= cur that needs a beat; done when none is left. Reads need every lane,
  // writes with skipping enabled need only lanes whose strobe slice is non-zero.
  function automatic lane_sel_t next_lane(input logic [MAX_LANES-1:0] strb, input int cur,
                                          input logic write, input logic skip, input int ratio);
    lane_sel_t sel;
    sel.done = 1'b1;
    sel.lane = '0;
    for (int l = MAX_LANES - 1; l >= 0; l--) begin
      if (l >= cur && l < ratio && (strb[l] || !(write && skip))) begin
        sel.done = 1'b0;
        sel.lane = LANE_SEL_W'(l);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/reg_intf_dw_downsizer.sv
// Splits one wide register-interface access into narrow beats, lowest lane first,
// reassembling read data and OR-ing beat errors into a single completion pulse.
module reg_intf_dw_downsizer
  import reg_intf_dw_pkg::*;
#(
  parameter int AW         = 32,
  parameter int WIDE_DW    = 64,
  parameter int NARROW_DW  = 32,
  parameter bit SKIP_EMPTY = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AW-1:0]          wide_addr_i,
  input  logic                   wide_write_i,
  input  logic [WIDE_DW-1:0]     wide_wdata_i,
  input  logic [WIDE_DW/8-1:0]   wide_wstrb_i,
  input  logic                   wide_valid_i,
  output logic [WIDE_DW-1:0]     wide_rdata_o,
  output logic                   wide_error_o,
  output logic                   wide_ready_o,
  output logic [AW-1:0]          narrow_addr_o,
  output logic                   narrow_write_o,
  output logic [NARROW_DW-1:0]   narrow_wdata_o,
  output logic [NARROW_DW/8-1:0] narrow_wstrb_o,
  output logic                   narrow_valid_o,
  input  logic [NARROW_DW-1:0]   narrow_rdata_i,
  input  logic                   narrow_error_i,
  input  logic                   narrow_ready_i
);

  localparam int RATIO = WIDE_DW / NARROW_DW;
  localparam int LW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int NB    = NARROW_DW / 8;
  localparam int WOFF  = $clog2(WIDE_DW / 8);
  localparam int NOFF  = $clog2(NB);

  if ((WIDE_DW % NARROW_DW) != 0 || (WIDE_DW & (WIDE_DW - 1)) != 0 ||
      (NARROW_DW & (NARROW_DW - 1)) != 0 || NARROW_DW < 8 || RATIO > MAX_LANES) begin : g_bad_cfg
    $error("reg_intf_dw_downsizer: WIDE_DW/NARROW_DW must be powers of 2 with WIDE_DW >= NARROW_DW >= 8");
  end

  state_e                r_state, w_state_nxt;
  logic [AW-1:0]         r_addr;
  logic                  r_write;
  logic [WIDE_DW-1:0]    r_wdata;
  logic [WIDE_DW/8-1:0]  r_wstrb;
  logic [LW-1:0]         r_lane;
  logic [WIDE_DW-1:0]    r_rdata;
  logic                  r_error;
  logic                  r_wready;
  logic                  r_nvalid;
  logic [AW-1:0]         r_naddr;
  logic [NARROW_DW-1:0]  r_nwdata;
  logic [NB-1:0]         r_nwstrb;

  logic [MAX_LANES-1:0]  w_in_any, w_lat_any;
  lane_sel_t             w_first, w_next;
  logic                  w_hs, w_load;
  logic [LW-1:0]         w_lane_nxt;
  logic [AW-1:0]         w_src_addr;
  logic [WIDE_DW-1:0]    w_src_wdata;
  logic [WIDE_DW/8-1:0]  w_src_wstrb;

  for (genvar l = 0; l < MAX_LANES; l++) begin : g_any
    if (l < RATIO) begin : g_on
      assign w_in_any[l]  = |wide_wstrb_i[l*NB +: NB];
      assign w_lat_any[l] = |r_wstrb[l*NB +: NB];
    end else begin : g_off
      assign w_in_any[l]  = 1'b0;
      assign w_lat_any[l] = 1'b0;
    end
  end

  assign w_hs    = r_nvalid & narrow_ready_i;
  assign w_first = next_lane(w_in_any, 0, wide_write_i, SKIP_EMPTY, RATIO);
  assign w_next  = next_lane(w_lat_any, int'(r_lane) + 1, r_write, SKIP_EMPTY, RATIO);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (wide_valid_i) w_state_nxt = w_first.done ? RESP : ISSUE;
      ISSUE:   if (w_hs && w_next.done) w_state_nxt = RESP;
      RESP:    if (r_wready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Beat loading: the first beat comes straight from the request inputs, later ones from the latch.
  always_comb begin
    w_load      = 1'b0;
    w_lane_nxt  = r_lane;
    w_src_addr  = r_addr;
    w_src_wdata = r_wdata;
    w_src_wstrb = r_wstrb;
    if (r_state == IDLE && wide_valid_i && !w_first.done) begin
      w_load      = 1'b1;
      w_lane_nxt  = LW'(w_first.lane);
      w_src_addr  = wide_addr_i;
      w_src_wdata = wide_wdata_i;
      w_src_wstrb = wide_wstrb_i;
    end else if (r_state == ISSUE && w_hs && !w_next.done) begin
      w_load     = 1'b1;
      w_lane_nxt = LW'(w_next.lane);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr   <= '0;
      r_write  <= 1'b0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_lane   <= '0;
      r_rdata  <= '0;
      r_error  <= 1'b0;
      r_wready <= 1'b0;
      r_nvalid <= 1'b0;
      r_naddr  <= '0;
      r_nwdata <= '0;
      r_nwstrb <= '0;
    end else begin
      // RESP spans two cycles so the pulse sits on a registered output.
      r_wready <= (r_state == RESP) && !r_wready;
      if (r_state == IDLE && wide_valid_i) begin
        r_addr  <= wide_addr_i;
        r_write <= wide_write_i;
        r_wdata <= wide_wdata_i;
        r_wstrb <= wide_wstrb_i;
        r_rdata <= '0;
        r_error <= 1'b0;
      end
      if (w_hs) begin
        r_rdata[r_lane*NARROW_DW +: NARROW_DW] <= narrow_rdata_i;
        r_error <= r_error | narrow_error_i;
      end
      if (w_load) begin
        r_nvalid <= 1'b1;
        r_lane   <= w_lane_nxt;
        r_naddr  <= ((w_src_addr >> WOFF) << WOFF) | (AW'(w_lane_nxt) << NOFF);
        r_nwdata <= w_src_wdata[w_lane_nxt*NARROW_DW +: NARROW_DW];
        r_nwstrb <= w_src_wstrb[w_lane_nxt*NB +: NB];
      end else if (w_hs) begin
        r_nvalid <= 1'b0;
      end
    end
  end

  assign wide_rdata_o   = r_rdata;
  assign wide_error_o   = r_error;
  assign wide_ready_o   = r_wready;
  assign narrow_addr_o  = r_naddr;
  assign narrow_write_o = r_write;
  assign narrow_wdata_o = r_nwdata;
  assign narrow_wstrb_o = r_nwstrb;
  assign narrow_valid_o = r_nvalid;

  // The master must hold its request until it sees the completion pulse.
  a_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (r_state != IDLE && !r_wready) |-> wide_valid_i);

endmodule

// File: tb/tb_reg_intf_dw_downsizer.sv
// Bench: three downsizers (32->32, 64->32, 128->32) sharing one master driver and one
// byte-addressed slave, checked against a byte-level reference memory.
module tb_reg_intf_dw_downsizer;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0]  m_addr = '0;
  logic           m_write = 1'b0;
  logic [127:0]   m_wdata = '0;
  logic [15:0]    m_wstrb = '0;
  logic           m_valid = 1'b0;
  logic [1:0]     sel = 2'd0;
  logic [2:0]     wv;

  logic [31:0]    rd0;
  logic [63:0]    rd1;
  logic [127:0]   rd2;
  logic [2:0]     err, rdy, nv, nw;
  logic [2:0][AW-1:0] na;
  logic [2:0][31:0]   nwd;
  logic [2:0][3:0]    nws;

  logic           s_ready = 1'b0;
  logic [31:0]    s_rdata = '0;
  logic           s_error = 1'b0;

  logic           c_nv, c_nw;
  logic [AW-1:0]  c_na;
  logic [31:0]    c_nwd;
  logic [3:0]     c_nws;

  assign wv[0] = m_valid && sel == 2'd0;
  assign wv[1] = m_valid && sel == 2'd1;
  assign wv[2] = m_valid && sel == 2'd2;
  assign c_nv  = nv[sel];
  assign c_nw  = nw[sel];
  assign c_na  = na[sel];
  assign c_nwd = nwd[sel];
  assign c_nws = nws[sel];

  reg_intf_dw_downsizer #(.AW(AW), .WIDE_DW(32), .NARROW_DW(32), .SKIP_EMPTY(1'b1)) u_r1 (
    .clk_i(clk), .rst_ni(rst_n), .wide_addr_i(m_addr), .wide_write_i(m_write),
    .wide_wdata_i(m_wdata[31:0]), .wide_wstrb_i(m_wstrb[3:0]), .wide_valid_i(wv[0]),
    .wide_rdata_o(rd0), .wide_error_o(err[0]), .wide_ready_o(rdy[0]),
    .narrow_addr_o(na[0]), .narrow_write_o(nw[0]), .narrow_wdata_o(nwd[0]), .narrow_wstrb_o(nws[0]),
    .narrow_valid_o(nv[0]), .narrow_rdata_i(s_rdata), .narrow_error_i(s_error), .narrow_ready_i(s_ready));

  reg_intf_dw_downsizer #(.AW(AW), .WIDE_DW(64), .NARROW_DW(32), .SKIP_EMPTY(1'b1)) u_r2 (
    .clk_i(clk), .rst_ni(rst_n), .wide_addr_i(m_addr), .wide_write_i(m_write),
    .wide_wdata_i(m_wdata[63:0]), .wide_wstrb_i(m_wstrb[7:0]), .wide_valid_i(wv[1]),
    .wide_rdata_o(rd1), .wide_error_o(err[1]), .wide_ready_o(rdy[1]),
    .narrow_addr_o(na[1]), .narrow_write_o(nw[1]), .narrow_wdata_o(nwd[1]), .narrow_wstrb_o(nws[1]),
    .narrow_valid_o(nv[1]), .narrow_rdata_i(s_rdata), .narrow_error_i(s_error), .narrow_ready_i(s_ready));

  reg_intf_dw_downsizer #(.AW(AW), .WIDE_DW(128), .NARROW_DW(32), .SKIP_EMPTY(1'b1)) u_r4 (
    .clk_i(clk), .rst_ni(rst_n), .wide_addr_i(m_addr), .wide_write_i(m_write),
    .wide_wdata_i(m_wdata), .wide_wstrb_i(m_wstrb), .wide_valid_i(wv[2]),
    .wide_rdata_o(rd2), .wide_error_o(err[2]), .wide_ready_o(rdy[2]),
    .narrow_addr_o(na[2]), .narrow_write_o(nw[2]), .narrow_wdata_o(nwd[2]), .narrow_wstrb_o(nws[2]),
    .narrow_valid_o(nv[2]), .narrow_rdata_i(s_rdata), .narrow_error_i(s_error), .narrow_ready_i(s_ready));

  int ntot = 0, npass = 0, nfail = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [127:0] rd_of(input int k);
    return (k == 0) ? {96'd0, rd0} : (k == 1) ? {64'd0, rd1} : rd2;
  endfunction

  // Slave: programmable wait states and per-beat error mask, byte memory, beat log.
  logic [7:0]    smem [logic [31:0]];
  logic [7:0]    refmem [logic [31:0]];
  int            s_waits = 0;
  logic [15:0]   s_errmask = '0;
  int            s_beat = 0;
  logic [31:0]   s_rd_ovr [$];
  logic [AW-1:0] log_addr [$];
  logic [31:0]   log_wdata [$];
  logic [3:0]    log_wstrb [$];

  initial begin
    int cnt;
    logic pv, pr, pw;
    logic [AW-1:0] pa;
    logic [31:0] pd;
    logic [3:0] ps;
    cnt = 0; pv = 1'b0; pr = 1'b0; pw = 1'b0; pa = '0; pd = '0; ps = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        s_ready = 1'b0; cnt = 0; pv = 1'b0; pr = 1'b0;
        continue;
      end
      if (pv && !pr && c_nv)
        chk("stable", {c_na, c_nw, c_nwd, c_nws}, {pa, pw, pd, ps});
      pv = c_nv; pa = c_na; pw = c_nw; pd = c_nwd; ps = c_nws;
      if (c_nv && cnt == s_waits) begin
        s_ready = 1'b1; cnt = 0;
        s_error = s_errmask[s_beat];
        s_beat++;
        log_addr.push_back(c_na); log_wdata.push_back(c_nwd); log_wstrb.push_back(c_nws);
        if (c_nw) begin
          for (int i = 0; i < 4; i++) if (c_nws[i]) smem[c_na + 32'(i)] = c_nwd[i*8 +: 8];
        end else if (s_rd_ovr.size() > 0) begin
          s_rdata = s_rd_ovr.pop_front();
        end else begin
          for (int i = 0; i < 4; i++)
            s_rdata[i*8 +: 8] = smem.exists(c_na + 32'(i)) ? smem[c_na + 32'(i)] : dflt(c_na + 32'(i));
        end
      end else begin
        s_ready = 1'b0;
        cnt = c_nv ? cnt + 1 : 0;
      end
      pr = s_ready;
    end
  end

  task automatic do_txn(input int k, input logic [31:0] a, input logic w, input logic [127:0] d,
                        input logic [15:0] s, output logic [127:0] rd, output logic er, output int cyc);
    @(negedge clk);
    sel = 2'(k); m_addr = a; m_write = w; m_wdata = d; m_wstrb = s; m_valid = 1'b1;
    s_beat = 0;
    log_addr.delete(); log_wdata.delete(); log_wstrb.delete();
    cyc = 0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (rdy[k]) break;
      if (cyc >= 300) begin
        ntot++; nfail++;
        $error("FAIL timeout: got no wide_ready_o after %0d cycles expected completion", cyc);
        break;
      end
    end
    rd = rd_of(k); er = err[k];
    m_valid = 1'b0;
  endtask

  // Reference: byte-addressed memory, beats = needed lanes, latency from the beat count.
  task automatic run_check(input string tag, input int k, input logic [31:0] a, input logic w,
                           input logic [127:0] d, input logic [15:0] s, input int waits,
                           input logic [15:0] emask, output logic [127:0] rd, output int cyc);
    int ratio, wb, beats, exp_cyc, j;
    logic [31:0] base;
    logic [127:0] exp_rd;
    logic er, exp_er;
    logic [31:0] exp_addr [$];
    ratio = 1 << k; wb = 4 * ratio;
    base = a & ~32'(wb - 1);
    s_waits = waits; s_errmask = emask;
    for (int l = 0; l < ratio; l++)
      if (!w || s[l*4 +: 4] != 4'h0) exp_addr.push_back(base + 32'(4 * l));
    beats = exp_addr.size();
    exp_er = |(emask & 16'((32'd1 << beats) - 1));
    exp_cyc = (beats == 0) ? 2 : 2 + beats * (waits + 1);
    exp_rd = '0;
    for (int b = 0; b < wb; b++)
      exp_rd[b*8 +: 8] = refmem.exists(base + 32'(b)) ? refmem[base + 32'(b)] : dflt(base + 32'(b));
    do_txn(k, a, w, d, s, rd, er, cyc);
    chk({tag, ".beats"}, 128'(log_addr.size()), 128'(beats));
    j = 0;
    foreach (exp_addr[i]) begin
      if (j < log_addr.size()) chk({tag, ".addr"}, 128'(log_addr[j]), 128'(exp_addr[i]));
      j++;
    end
    chk({tag, ".err"}, 128'(er), 128'(exp_er));
    chk({tag, ".lat"}, 128'(cyc), 128'(exp_cyc));
    if (!w) chk({tag, ".rdata"}, rd, exp_rd);
    else for (int b = 0; b < wb; b++) if (s[b]) refmem[base + 32'(b)] = d[b*8 +: 8];
  endtask

  initial begin
    logic [127:0] rd;
    logic er;
    int cyc;
    logic saw;

    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_out", {rdy[k], err[k], nv[k], nw[k], na[k], nwd[k], nws[k]}, '0);
      chk("rst_rdata", rd_of(k), '0);
    end
    rst_n = 1'b1;

    // 64->32 read with scripted slave data
    s_waits = 0; s_errmask = '0;
    s_rd_ovr.push_back(32'hAAAA0000); s_rd_ovr.push_back(32'h5555FFFF);
    do_txn(1, 32'h1004, 1'b0, '0, '0, rd, er, cyc);
    chk("d1.rdata", rd, 128'h5555FFFF_AAAA0000);
    chk("d1.err", 128'(er), 0);
    chk("d1.nbeats", 128'(log_addr.size()), 2);
    if (log_addr.size() == 2) begin
      chk("d1.addr0", 128'(log_addr[0]), 128'h1000);
      chk("d1.addr1", 128'(log_addr[1]), 128'h1004);
    end
    chk("d1.lat", 128'(cyc), 4);

    // 64->32 write with only the upper lane strobed
    run_check("d2", 1, 32'h1000, 1'b1, 128'h11223344_55667788, 16'h00F0, 0, '0, rd, cyc);
    if (log_addr.size() == 1) begin
      chk("d2.wdata", 128'(log_wdata[0]), 128'h11223344);
      chk("d2.wstrb", 128'(log_wstrb[0]), 128'hF);
    end

    // all-empty write: no beat, completion at cycle 2
    run_check("d3", 1, 32'h1008, 1'b1, 128'hDEAD, 16'h0000, 0, '0, rd, cyc);
    chk("d3.lat", 128'(cyc), 2);

    // 128->32 read, error on beat 1, two wait states
    run_check("d4", 2, 32'h4000, 1'b0, '0, '0, 2, 16'h0002, rd, cyc);
    chk("d4.lat", 128'(cyc), 14);
    chk("d4.err", 128'(err[2]), 1);

    // reset during beat 2 of 4
    s_waits = 2; s_errmask = '0;
    @(negedge clk);
    sel = 2'd2; m_addr = 32'h3000; m_write = 1'b0; m_valid = 1'b1; s_beat = 0;
    saw = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (c_nv && c_na == 32'h3004) begin saw = 1'b1; break; end
    end
    chk("rst.reached_beat2", 128'(saw), 1);
    #2 rst_n = 1'b0; m_valid = 1'b0;
    #1 chk("rst.nvalid", 128'(c_nv), 0);
    chk("rst.ready", 128'(rdy[2]), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (|rdy || |nv) saw = 1'b1;
    end
    chk("rst.no_completion", 128'(saw), 0);
    run_check("rst.next", 2, 32'h3000, 1'b0, '0, '0, 0, '0, rd, cyc);

    // random back-to-back traffic across ratios 1, 2, 4
    for (int it = 0; it < 150; it++) begin
      int k, waits;
      logic [31:0] a;
      logic w;
      logic [127:0] d;
      logic [15:0] s, em;
      k = $urandom_range(0, 2);
      a = 32'h2000 | 32'($urandom_range(0, 255));
      w = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom, $urandom, $urandom};
      for (int l = 0; l < 4; l++) s[l*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      waits = $urandom_range(0, 2);
      em = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      run_check("rnd", k, a, w, d, s, waits, em, rd, cyc);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
